// File: rtl/shift_reg_n_if.sv
// Control/data bundle for shift_reg_n: operation requests in, register state and status out.
interface shift_reg_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             set;
    logic             ld_str;
    logic [WIDTH-1:0] d_in;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             sl_in;
    logic             sr_in;
    logic [WIDTH-1:0] q;
    logic             sl_out;
    logic             sr_out;
    logic             cy;
    logic             busy;
    logic             done;

    modport master (
        output set, ld_str, d_in, start, mode, amount, sl_in, sr_in,
        input  q, sl_out, sr_out, cy, busy, done
    );

    modport slave (
        input  set, ld_str, d_in, start, mode, amount, sl_in, sr_in,
        output q, sl_out, sr_out, cy, busy, done
    );
endinterface

// File: rtl/shift_reg_n.sv
// Multi-step shift/rotate/count register with load, preset and a
// start/busy/done sequencer performing one step per clock.
module shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic         clk,
    input logic         clr,
    shift_reg_n_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic             cy_r;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mode_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] step_q;
    logic             step_cy;

    // Result of one step of the latched operation applied to the current register.
    always_comb begin
        step_q  = q_r;
        step_cy = cy_r;
        case (mode_r)
            3'b000: begin step_q = {q_r[WIDTH-2:0], bus.sl_in};  step_cy = q_r[WIDTH-1]; end
            3'b001: begin step_q = {bus.sr_in, q_r[WIDTH-1:1]};  step_cy = q_r[0];       end
            3'b010: begin step_q = {q_r[WIDTH-2:0], q_r[WIDTH-1]}; step_cy = q_r[WIDTH-1]; end
            3'b011: begin step_q = {q_r[0], q_r[WIDTH-1:1]};     step_cy = q_r[0];       end
            3'b100: begin step_q = {q_r[WIDTH-1], q_r[WIDTH-1:1]}; step_cy = q_r[0];     end
            3'b101: begin step_q = q_r + 1'b1;                   step_cy = &q_r;         end
            3'b110: begin step_q = q_r - 1'b1;                   step_cy = ~|q_r;        end
            default: begin step_q = q_r;                         step_cy = cy_r;         end
        endcase
    end

    // Sequencer and datapath: clr > set > load (IDLE) > start; one step per RUN edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            q_r    <= '0;
            cy_r   <= 1'b0;
            cnt    <= '0;
            mode_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.set) begin
            state  <= IDLE;
            q_r    <= '1;
            cy_r   <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.ld_str) begin
                        q_r  <= bus.d_in;
                        cy_r <= 1'b0;
                    end else if (bus.start) begin
                        mode_r <= bus.mode;
                        if (bus.amount != '0) begin
                            cnt    <= bus.amount;
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_r  <= step_q;
                    cy_r <= step_cy;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q      = q_r;
    assign bus.sl_out = q_r[WIDTH-1];
    assign bus.sr_out = q_r[0];
    assign bus.cy     = cy_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_shift_reg_n.sv
// Directed bench for shift_reg_n (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_shift_reg_n;
    logic clk = 1'b0;
    logic clr;
    int   checks   = 0;
    int   failures = 0;

    shift_reg_n_if #(.WIDTH(8), .CNT_W(4)) bus ();

    shift_reg_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] q, input logic cy,
                          input logic busy, input logic done);
        chk({tag, ".q"}, 32'(bus.q), 32'(q));
        chk({tag, ".cy"}, 32'(bus.cy), 32'(cy));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
        chk({tag, ".done"}, 32'(bus.done), 32'(done));
    endtask

    task automatic load(input logic [7:0] v);
        bus.ld_str = 1'b1; bus.d_in = v;
        tick();
        bus.ld_str = 1'b0;
    endtask

    task automatic go(input logic [2:0] m, input logic [3:0] n);
        bus.start = 1'b1; bus.mode = m; bus.amount = n;
        tick();
        bus.start = 1'b0; bus.mode = 3'b111; bus.amount = 4'd0;
    endtask

    initial begin
        bus.set = 1'b1; bus.ld_str = 1'b1; bus.d_in = 8'h5A; bus.start = 1'b1;
        bus.mode = 3'b101; bus.amount = 4'd3; bus.sl_in = 1'b0; bus.sr_in = 1'b0;
        clr = 1'b1;

        // clr overrides everything
        tick();
        chk_st("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; bus.set = 1'b0; bus.ld_str = 1'b0; bus.start = 1'b0;

        // ROL A5 by 3
        load(8'hA5);
        chk_st("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        go(3'b010, 4'd3);
        chk_st("rol_start", 8'hA5, 1'b0, 1'b1, 1'b0);
        tick(); chk_st("rol_s1", 8'h4B, 1'b1, 1'b1, 1'b0);
        tick(); chk_st("rol_s2", 8'h96, 1'b0, 1'b1, 1'b0);
        tick(); chk_st("rol_s3", 8'h2D, 1'b1, 1'b0, 1'b1);
        tick(); chk_st("rol_idle", 8'h2D, 1'b1, 1'b0, 1'b0);

        // INC wrap from FE
        load(8'hFE);
        go(3'b101, 4'd3);
        tick(); chk_st("inc_s1", 8'hFF, 1'b0, 1'b1, 1'b0);
        tick(); chk_st("inc_s2", 8'h00, 1'b1, 1'b1, 1'b0);
        tick(); chk_st("inc_s3", 8'h01, 1'b0, 1'b0, 1'b1);
        tick(); chk("inc_done_low", 32'(bus.done), 32'd0);

        // ASR 81 by 2
        load(8'h81);
        go(3'b100, 4'd2);
        tick(); chk_st("asr_s1", 8'hC0, 1'b1, 1'b1, 1'b0);
        tick(); chk_st("asr_s2", 8'hE0, 1'b0, 1'b0, 1'b1);
        chk("asr_sr_out", 32'(bus.sr_out), 32'd0);
        chk("asr_sl_out", 32'(bus.sl_out), 32'd1);
        tick();

        // amount=0: straight to DONE, q untouched
        go(3'b000, 4'd0);
        chk_st("zero_done", 8'hE0, 1'b0, 1'b0, 1'b1);
        tick(); chk_st("zero_idle", 8'hE0, 1'b0, 1'b0, 1'b0);

        // SHR by 5 aborted by set after step 1
        bus.sr_in = 1'b0;
        go(3'b001, 4'd5);
        tick(); chk_st("shr_s1", 8'h70, 1'b0, 1'b1, 1'b0);
        bus.set = 1'b1;
        tick(); chk_st("set_abort", 8'hFF, 1'b0, 1'b0, 1'b0);
        bus.set = 1'b0;
        tick(); chk_st("set_no_done", 8'hFF, 1'b0, 1'b0, 1'b0);

        // ld_str/start during RUN and DONE are ignored
        load(8'h0F);
        bus.sl_in = 1'b1;
        go(3'b000, 4'd2);
        bus.ld_str = 1'b1; bus.d_in = 8'h00; bus.start = 1'b1; bus.mode = 3'b110; bus.amount = 4'd1;
        tick(); chk_st("shl_s1", 8'h1F, 1'b0, 1'b1, 1'b0);
        tick(); chk_st("shl_s2", 8'h3F, 1'b0, 1'b0, 1'b1);
        bus.ld_str = 1'b0; bus.start = 1'b0;
        tick(); chk_st("shl_idle", 8'h3F, 1'b0, 1'b0, 1'b0);

        // SHR with sr_in=1, then DEC borrow from 00
        bus.sr_in = 1'b1;
        go(3'b001, 4'd1);
        tick(); chk_st("shr1_s1", 8'h9F, 1'b1, 1'b0, 1'b1);
        tick();
        load(8'h00);
        go(3'b110, 4'd1);
        tick(); chk_st("dec_s1", 8'hFF, 1'b1, 1'b0, 1'b1);
        tick();

        // ROR and HOLD modes
        load(8'h01);
        go(3'b011, 4'd1);
        tick(); chk_st("ror_s1", 8'h80, 1'b1, 1'b0, 1'b1);
        tick();
        go(3'b111, 4'd2);
        tick(); chk_st("hold_s1", 8'h80, 1'b1, 1'b1, 1'b0);
        tick(); chk_st("hold_s2", 8'h80, 1'b1, 1'b0, 1'b1);
        tick();

        // clr mid-run
        load(8'h3C);
        go(3'b010, 4'd4);
        tick();
        clr = 1'b1;
        tick(); chk_st("clr_abort", 8'h00, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        tick(); chk_st("clr_no_done", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_reg_n.md
SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter CNT_W, default 4, width of step-count input; max steps 2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port clr  input  1  reset; synchronous, active-high; clears register and control.
REQ-005 SHALL have port set  input  1  synchronous active-high preset; register to all ones.
REQ-006 SHALL have port ld_str  input  1  parallel load strobe.
REQ-007 SHALL have port d_in  input  WIDTH  parallel load data.
REQ-008 SHALL have port start  input  1  begin multi-step operation.
REQ-009 SHALL have port mode  input  3  operation select, sampled with start.
REQ-010 SHALL have port amount  input  CNT_W  step count, sampled with start.
REQ-011 SHALL have port sl_in  input  1  serial fill bit for left shift (enters bit 0).
REQ-012 SHALL have port sr_in  input  1  serial fill bit for logical right shift (enters bit WIDTH-1).
REQ-013 SHALL have port q  output  WIDTH  register contents.
REQ-014 SHALL have port sl_out  output  1  q[WIDTH-1]; sr_out  output  1  q[0].
REQ-015 SHALL have port cy  output  1  registered carry/borrow/shifted-out flag.
REQ-016 SHALL have port busy  output  1  high in RUN; done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-018 Priority per edge SHALL be clr > set > (IDLE only) ld_str > start.
REQ-019 set SHALL load q=all ones, cy=0, state=IDLE, aborting any operation.
REQ-020 ld_str in IDLE SHALL load q=d_in, cy=0, in one edge; start same cycle ignored.
REQ-021 start in IDLE SHALL latch mode, amount; amount>0 -> RUN with counter=amount; amount=0 -> DONE, q and cy unchanged.
REQ-022 In RUN each edge SHALL perform exactly one step and decrement counter; step N (last) -> DONE.
REQ-023 Latency SHALL be: start sampled at edge k, steps at edges k+1..k+N, done high in cycle after edge k+N, IDLE after next edge.
REQ-024 ld_str and start SHALL be ignored in RUN and DONE; mode/amount changes after start SHALL have no effect.
REQ-025 Modes SHALL be: 000 SHL (fill sl_in, cy=old q[W-1]); 001 SHR (fill sr_in, cy=old q[0]); 010 ROL; 011 ROR (cy=bit rotated).
REQ-026 Modes SHALL continue: 100 ASR (MSB replicated, cy=old q[0]); 101 INC modulo 2^WIDTH (cy=1 iff old q all ones); 110 DEC modulo 2^WIDTH (cy=1 iff old q=0).
REQ-027 Mode 111 SHALL hold q and cy for N steps, still asserting busy and done.
REQ-028 cy SHALL reflect only the most recent step; sl_in/sr_in sampled at each step edge.
REQ-029 clr or set asserted mid-RUN SHALL abort at that edge; no done pulse issued.

Reset
REQ-030 clr SHALL force q=0, cy=0, state=IDLE, counter=0, busy=0, done=0 at next rising edge, overriding all inputs.
REQ-031 Outputs SHALL be undefined only before first clk edge with clr high; no asynchronous path.

Verification
REQ-032 WIDTH=8: clr=1 one edge with set=ld_str=start=1 -> q=00, cy=0, busy=0, done=0.
REQ-033 ld_str, d_in=A5; start mode=010 amount=3 -> busy 3 cycles, q=2D, cy=1, done one cycle after step 3.
REQ-034 q=FE; start mode=101 amount=3 -> q=FF, 00, 01 per step; final cy=0, cy=1 after step 2.
REQ-035 q=81; start mode=100 amount=2 -> q=C0 then E0, cy=0; sr_out=0, sl_out=1.
REQ-036 start amount=0 -> done next cycle, busy never high, q unchanged; start mode=001 amount=5 with set at step 2 -> q=FF, IDLE, no done.
REQ-037 ld_str and start asserted during RUN -> ignored; q follows only the latched operation.
